// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: fetch PC, imem req/ack port, branch redirect, stale-response kill.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_branch,
  input  logic        i_zero,
  input  logic [31:0] i_br_pc,
  input  logic [31:0] i_branch_off,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_pc,
  output logic        o_misalign_trap,
  output logic [31:0] o_trap_addr
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_KILL, ST_HOLD} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_kill_addr;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;

  logic        w_redirect;
  logic [31:0] w_raw_target;
  logic [31:0] w_target;

  assign w_redirect   = i_branch & i_zero;
  assign w_raw_target = i_br_pc + i_branch_off;

`ifdef MISALIGN_TRAP_EN
  logic        r_misalign_trap;
  logic [31:0] r_trap_addr;
  logic        w_misaligned;

  assign w_misaligned = |w_raw_target[1:0];
  assign w_target     = w_misaligned ? TRAP_VEC : w_raw_target;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign_trap <= 1'b0;
      r_trap_addr     <= 32'h0;
    end else begin
      r_misalign_trap <= w_redirect & w_misaligned;
      if (w_redirect & w_misaligned)
        r_trap_addr <= w_raw_target;
    end
  end

  assign o_misalign_trap = r_misalign_trap;
  assign o_trap_addr     = r_trap_addr;
`else
  assign w_target        = w_raw_target & 32'hFFFF_FFFC;
  assign o_misalign_trap = 1'b0;
  assign o_trap_addr     = 32'h0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: w_next_state = ST_REQ;
      ST_REQ: begin
        if (w_redirect)      w_next_state = i_imem_ack ? ST_REQ : ST_KILL;
        else if (i_imem_ack) w_next_state = ST_HOLD;
      end
      ST_KILL: if (i_imem_ack) w_next_state = ST_REQ;
      ST_HOLD: if (w_redirect || !i_stall) w_next_state = ST_REQ;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_imem_req  = (r_state == ST_REQ) || (r_state == ST_KILL);
    o_imem_addr = (r_state == ST_KILL) ? r_kill_addr : r_pc;
  end

  // Redirect wins over a same-cycle ack, so a response racing a redirect is never captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc        <= RESET_PC;
      r_kill_addr <= 32'h0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= 32'h0;
      r_if_instr  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_redirect) r_pc <= w_target;
        ST_REQ: begin
          if (w_redirect) begin
            r_pc <= w_target;
            if (!i_imem_ack) r_kill_addr <= r_pc;
          end else if (i_imem_ack) begin
            r_if_instr <= i_imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + 32'd4;
          end
        end
        ST_KILL: if (w_redirect) r_pc <= w_target;
        ST_HOLD: begin
          if (w_redirect) begin
            r_if_valid <= 1'b0;
            r_pc       <= w_target;
          end else if (!i_stall) begin
            r_if_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pc       = r_pc;
  assign o_if_valid = r_if_valid;
  assign o_if_pc    = r_if_pc;
  assign o_if_instr = r_if_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, branch, zero, stall, imem_ack;
  logic [31:0] br_pc, branch_off, imem_rdata;
  logic        imem_req, if_valid, misalign_trap;
  logic [31:0] imem_addr, if_pc, if_instr, pc, trap_addr;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] EXP_MIS_PC   = 32'h0000_0100;
  localparam logic        EXP_TRAP     = 1'b1;
  localparam logic [31:0] EXP_TRAP_ADR = 32'h0000_0022;
`else
  localparam logic [31:0] EXP_MIS_PC   = 32'h0000_0020;
  localparam logic        EXP_TRAP     = 1'b0;
  localparam logic [31:0] EXP_TRAP_ADR = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_branch(branch), .i_zero(zero), .i_br_pc(br_pc),
    .i_branch_off(branch_off), .i_stall(stall), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .o_if_valid(if_valid), .o_if_pc(if_pc),
    .o_if_instr(if_instr), .o_pc(pc), .o_misalign_trap(misalign_trap), .o_trap_addr(trap_addr)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; branch = 0; zero = 0; stall = 0; imem_ack = 0;
    br_pc = 0; branch_off = 0; imem_rdata = 0;
    step(); step();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
    n_cmp++; if (misalign_trap !== 1'b0) begin n_err++; $display("FAIL rst_trap got=%b exp=0", misalign_trap); end
    rst = 1'b0;
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req got=%b exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_fetch();
    step();
    n_cmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL req_stable got=%b/%h exp=1/0", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h11;
    step();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL f0_valid got=%b exp=1", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL f0_if_pc got=%h exp=0", if_pc); end
    n_cmp++; if (if_instr !== 32'h11) begin n_err++; $display("FAIL f0_instr got=%h exp=11", if_instr); end
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL f0_pc got=%h exp=4", pc); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL f0_hold_req got=%b exp=0", imem_req); end
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL f1_req got=%b/%h exp=1/4", imem_req, imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL f0_consumed got=%b exp=0", if_valid); end
    imem_ack = 1; imem_rdata = 32'h22;
    step();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h22) begin n_err++; $display("FAIL f1_out got=%b/%h/%h exp=1/4/22", if_valid, if_pc, if_instr); end
    n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL f1_pc got=%h exp=8", pc); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (if_valid !== 1'b1 || if_instr !== 32'h22) begin n_err++; $display("FAIL stall_hold%0d got=%b/%h exp=1/22", i, if_valid, if_instr); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req%0d got=%b exp=0", i, imem_req); end
    end
    stall = 0;
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_release got=%b/%h exp=1/8", imem_req, imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid got=%b exp=0", if_valid); end
  endtask

  task automatic test_redirect_hold();
    imem_ack = 1; imem_rdata = 32'h33;
    step();
    imem_ack = 0;
    n_cmp++; if (if_pc !== 32'h8 || if_instr !== 32'h33 || pc !== 32'hC) begin n_err++; $display("FAIL f2_out got=%h/%h/%h exp=8/33/c", if_pc, if_instr, pc); end
    stall = 1; branch = 1; zero = 0; br_pc = 32'h8; branch_off = 32'h20;
    step();
    n_cmp++; if (if_valid !== 1'b1 || pc !== 32'hC || imem_req !== 1'b0) begin n_err++; $display("FAIL no_redirect got=%b/%h/%b exp=1/c/0", if_valid, pc, imem_req); end
    zero = 1;
    step();
    branch = 0; zero = 0; stall = 0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL hold_redir_valid got=%b exp=0", if_valid); end
    n_cmp++; if (pc !== 32'h28) begin n_err++; $display("FAIL hold_redir_pc got=%h exp=28", pc); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h28) begin n_err++; $display("FAIL hold_redir_addr got=%b/%h exp=1/28", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h44;
    step();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h28 || if_instr !== 32'h44 || pc !== 32'h2C) begin n_err++; $display("FAIL f3_out got=%b/%h/%h/%h exp=1/28/44/2c", if_valid, if_pc, if_instr, pc); end
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h2C) begin n_err++; $display("FAIL f4_req got=%b/%h exp=1/2c", imem_req, imem_addr); end
  endtask

  task automatic test_kill();
    branch = 1; zero = 1; br_pc = 32'h20; branch_off = 32'h20;
    step();
    branch = 0; zero = 0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h2C) begin n_err++; $display("FAIL kill_addr0 got=%b/%h exp=1/2c", imem_req, imem_addr); end
    n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL kill_pc got=%h exp=40", pc); end
    step();
    n_cmp++; if (imem_addr !== 32'h2C || if_valid !== 1'b0) begin n_err++; $display("FAIL kill_addr1 got=%h/%b exp=2c/0", imem_addr, if_valid); end
    imem_ack = 1; imem_rdata = 32'hDEAD;
    step();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h44) begin n_err++; $display("FAIL kill_drop got=%b/%h exp=0/44", if_valid, if_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL kill_next got=%b/%h exp=1/40", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1; imem_rdata = 32'hBEEF; branch = 1; zero = 1; br_pc = 32'h40; branch_off = 32'h40;
    step();
    imem_ack = 0; branch = 0; zero = 0;
    n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h44) begin n_err++; $display("FAIL race_drop got=%b/%h exp=0/44", if_valid, if_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || pc !== 32'h80) begin n_err++; $display("FAIL race_req got=%b/%h/%h exp=1/80/80", imem_req, imem_addr, pc); end
  endtask

  task automatic test_misalign();
    branch = 1; zero = 1; br_pc = 32'h0; branch_off = 32'h22;
    step();
    branch = 0; zero = 0;
    n_cmp++; if (pc !== EXP_MIS_PC) begin n_err++; $display("FAIL mis_pc got=%h exp=%h", pc, EXP_MIS_PC); end
    n_cmp++; if (misalign_trap !== EXP_TRAP) begin n_err++; $display("FAIL mis_trap got=%b exp=%b", misalign_trap, EXP_TRAP); end
    n_cmp++; if (trap_addr !== EXP_TRAP_ADR) begin n_err++; $display("FAIL mis_trap_addr got=%h exp=%h", trap_addr, EXP_TRAP_ADR); end
    n_cmp++; if (imem_addr !== 32'h80) begin n_err++; $display("FAIL mis_kill_addr got=%h exp=80", imem_addr); end
    step();
    n_cmp++; if (misalign_trap !== 1'b0) begin n_err++; $display("FAIL mis_trap_pulse got=%b exp=0", misalign_trap); end
    imem_ack = 1; imem_rdata = 32'h55;
    step();
    imem_ack = 0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== EXP_MIS_PC || if_valid !== 1'b0) begin n_err++; $display("FAIL mis_next got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, if_valid, EXP_MIS_PC); end
  endtask

  task automatic test_reset_mid();
    rst = 1; imem_ack = 1; imem_rdata = 32'h99;
    step();
    rst = 0;
    n_cmp++; if (imem_req !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL mid_rst got=%b/%h exp=0/0", imem_req, pc); end
    n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || trap_addr !== 32'h0) begin n_err++; $display("FAIL mid_rst_out got=%b/%h/%h exp=0/0/0", if_valid, if_instr, trap_addr); end
    step();
    imem_ack = 0;
    n_cmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin n_err++; $display("FAIL idle_ack_ignored got=%b/%h exp=0/0", if_valid, if_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_req got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_hold();
    test_kill();
    test_redirect_ack();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
